// File: rtl/lcd_pcf8574_feeder.sv
// Feeds HD44780 bytes to a PCF8574 I2C expander in 4-bit mode: power-on init,
// then each accepted byte becomes four expander writes followed by a settle delay.
module lcd_pcf8574_feeder #(
  parameter int SIM        = 0,
  parameter int CYC_PER_US = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_rs,
  input  logic       backlight,
  output logic [7:0] i2c_data,
  output logic       i2c_write_ena,
  input  logic       i2c_busy,
  input  logic       i2c_error,
  output logic       init_done,
  output logic       err
);

  localparam logic [31:0] CPU = (SIM != 0) ? 32'd1 : 32'(CYC_PER_US);

  typedef enum logic [2:0] {
    RESET_WAIT, INIT_NIB, INIT_DLY, IDLE, SEND, WAIT_START, WAIT_DONE, POST_DLY
  } state_t;

  function automatic logic [31:0] us_load(input logic [31:0] us);
    return us * CPU - 32'd1;
  endfunction

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic        armed, armed_n;
  logic [1:0]  init_idx, init_idx_n;
  logic [1:0]  wr_idx, wr_idx_n;
  logic [7:0]  i2c_data_n;
  logic        write_ena_n;
  logic        init_done_n;
  logic        err_n;
  logic        accept;

  logic [7:0]  data_q;
  logic        rs_q;
  logic        bl_q;
  logic [7:0]  wr_byte;

  assign in_ready = (state == IDLE) && init_done;
  assign accept   = in_valid && in_ready;

  // Even write index raises EN, odd index drops it; the upper index bit picks
  // the low nibble. Init nibbles use the live backlight level.
  always_comb begin
    wr_byte = 8'h00;
    if (init_done) begin
      wr_byte = {(wr_idx[1] ? data_q[3:0] : data_q[7:4]), bl_q, ~wr_idx[0], 1'b0, rs_q};
    end else begin
      wr_byte = {((init_idx == 2'd3) ? 4'h2 : 4'h3), backlight, ~wr_idx[0], 1'b0, 1'b0};
    end
  end

  // NOTE: every signal written here gets a default first, otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    armed_n     = armed;
    init_idx_n  = init_idx;
    wr_idx_n    = wr_idx;
    i2c_data_n  = i2c_data;
    write_ena_n = 1'b0;
    init_done_n = init_done;
    err_n       = err;

    case (state)
      RESET_WAIT: begin
        // Counter comes out of reset at zero, so the power-on wait is armed here.
        if (!armed) begin
          cnt_n   = us_load(32'd40000);
          armed_n = 1'b1;
        end else if (cnt == 32'd0) begin
          state_n = INIT_NIB;
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      INIT_NIB: begin
        wr_idx_n = 2'd0;
        state_n  = SEND;
      end
      INIT_DLY: begin
        if (cnt == 32'd0) begin
          if (init_idx == 2'd3) begin
            init_done_n = 1'b1;
            state_n     = IDLE;
          end else begin
            init_idx_n = init_idx + 2'd1;
            state_n    = INIT_NIB;
          end
        end else begin
          cnt_n = cnt - 32'd1;
        end
      end
      IDLE: begin
        if (accept) begin
          wr_idx_n = 2'd0;
          state_n  = SEND;
        end
      end
      SEND: begin
        if (!i2c_busy) begin
          write_ena_n = 1'b1;
          i2c_data_n  = wr_byte;
          state_n     = WAIT_START;
        end
      end
      WAIT_START: begin
        if (i2c_busy) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (!i2c_busy) begin
          if (i2c_error) err_n = 1'b1;
          if (!init_done) begin
            if (wr_idx == 2'd1) begin
              cnt_n   = (init_idx == 2'd0) ? us_load(32'd4100) : us_load(32'd100);
              state_n = INIT_DLY;
            end else begin
              wr_idx_n = wr_idx + 2'd1;
              state_n  = SEND;
            end
          end else if (wr_idx == 2'd3) begin
            // Clear and home need the long settle time.
            cnt_n   = (!rs_q && (data_q <= 8'h03)) ? us_load(32'd2000) : us_load(32'd50);
            state_n = POST_DLY;
          end else begin
            wr_idx_n = wr_idx + 2'd1;
            state_n  = SEND;
          end
        end
      end
      POST_DLY: begin
        if (cnt == 32'd0) state_n = IDLE;
        else              cnt_n   = cnt - 32'd1;
      end
      default: state_n = RESET_WAIT;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RESET_WAIT;
      cnt           <= 32'd0;
      armed         <= 1'b0;
      init_idx      <= 2'd0;
      wr_idx        <= 2'd0;
      i2c_data      <= 8'h00;
      i2c_write_ena <= 1'b0;
      init_done     <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      armed         <= armed_n;
      init_idx      <= init_idx_n;
      wr_idx        <= wr_idx_n;
      i2c_data      <= i2c_data_n;
      i2c_write_ena <= write_ena_n;
      init_done     <= init_done_n;
      err           <= err_n;
    end
  end

  // NOTE: the byte holding registers carry no reset; they are only read after
  // an acceptance has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= in_data;
      rs_q   <= in_rs;
      bl_q   <= backlight;
    end
  end

endmodule

// File: tb/tb_lcd_pcf8574_feeder.sv
// Randomized bench for lcd_pcf8574_feeder: a modelled I2C byte writer, a write
// monitor, and a scoreboard of expander bytes and settle delays built from the LCD rules.
module tb_lcd_pcf8574_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_rs = 1'b0;
  logic       backlight = 1'b1;
  logic [7:0] i2c_data;
  logic       i2c_write_ena;
  logic       i2c_busy;
  logic       i2c_error = 1'b0;
  logic       init_done;
  logic       err;

  logic       busy_w = 1'b0;
  logic       busy_hold = 1'b0;
  assign i2c_busy = busy_w | busy_hold;

  lcd_pcf8574_feeder #(.SIM(1), .CYC_PER_US(100)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rs(in_rs),
    .backlight(backlight),
    .i2c_data(i2c_data), .i2c_write_ena(i2c_write_ena),
    .i2c_busy(i2c_busy), .i2c_error(i2c_error),
    .init_done(init_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Writer model: busy for busy_len cycles per accepted write; error flag
  // reported with the busy fall of write number err_pick.
  int   busy_len = 5;
  int   wr_left  = 0;
  int   w_issued = 0;
  int   err_pick = -1;
  logic cur_err  = 1'b0;

  always @(posedge clk) begin
    if (wr_left > 0) begin
      wr_left <= wr_left - 1;
      if (wr_left == 1) begin
        busy_w    <= 1'b0;
        i2c_error <= cur_err;
      end
    end else if (i2c_write_ena) begin
      busy_w    <= 1'b1;
      wr_left   <= busy_len;
      w_issued  <= w_issued + 1;
      cur_err   <= ((w_issued + 1) == err_pick);
      i2c_error <= 1'b0;
    end
  end

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         ena_q[$];
  int         fall_q[$];
  logic [7:0] last_data = 8'h00;
  logic       ena_prev = 1'b0;
  logic       wbusy_prev = 1'b0;
  logic       done_prev = 1'b0;
  logic       chk_stable = 1'b1;
  int         done_cyc = -1;
  int         ena_bad = 0;
  int         stable_bad = 0;
  int         ready_init_bad = 0;

  always @(negedge clk) begin
    if (i2c_write_ena) begin
      if (i2c_busy || ena_prev) ena_bad++;
      got_q.push_back(i2c_data);
      ena_q.push_back(cyc);
      last_data = i2c_data;
    end else if (chk_stable && i2c_busy && (i2c_data !== last_data)) begin
      stable_bad++;
    end
    if (wbusy_prev && !busy_w) fall_q.push_back(cyc);
    if (!init_done && in_ready) ready_init_bad++;
    if (init_done && !done_prev) done_cyc = cyc;
    ena_prev   = i2c_write_ena;
    wbusy_prev = busy_w;
    done_prev  = init_done;
  end

  function automatic logic [7:0] pcf(input logic [3:0] nib, input logic bl,
                                     input logic en, input logic rs);
    return {nib, bl, en, 1'b0, rs};
  endfunction

  function automatic int post_us(input logic [7:0] d, input logic rs);
    return (!rs && d <= 8'h03) ? 2000 : 50;
  endfunction

  function automatic int fall_at(input int idx);
    return (idx < fall_q.size()) ? fall_q[idx] : -100000;
  endfunction

  function automatic int ena_at(input int idx);
    return (idx < ena_q.size()) ? ena_q[idx] : -100000;
  endfunction

  task automatic expect_byte(input logic [7:0] d, input logic rs, input logic bl);
    exp_q.push_back(pcf(d[7:4], bl, 1'b1, rs));
    exp_q.push_back(pcf(d[7:4], bl, 1'b0, rs));
    exp_q.push_back(pcf(d[3:0], bl, 1'b1, rs));
    exp_q.push_back(pcf(d[3:0], bl, 1'b0, rs));
  endtask

  // Called on a negedge; returns the cycle in_ready was seen, then scrambles
  // the byte inputs so a missing latch would show up in the writes.
  task automatic send_byte(input logic [7:0] d, input logic rs, input logic bl,
                           input int limit, output int acc_cyc);
    logic seen;
    seen     = 1'b0;
    acc_cyc  = -1;
    in_data  = d;
    in_rs    = rs;
    backlight = bl;
    in_valid = 1'b1;
    for (int k = 0; k < limit && !seen; k++) begin
      seen = in_ready;
      if (seen) acc_cyc = cyc;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_data   = 8'($urandom);
    in_rs     = 1'($urandom);
    backlight = 1'($urandom);
    check("accepted", seen, 1'b1);
    expect_byte(d, rs, bl);
  endtask

  task automatic wait_ready(input int limit, output int rc);
    rc = -1;
    for (int k = 0; k < limit && rc < 0; k++) begin
      if (in_ready) rc = cyc;
      else          @(negedge clk);
    end
    check("ready_in_time", rc >= 0, 1'b1);
  endtask

  initial begin
    repeat (98000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d expected finish before it", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, rc, base, prev_base, prev_us, g, clr_base;
    logic [7:0] d;
    logic rs, bl;

    rst = 1'b1;
    backlight = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_ena", i2c_write_ena, 1'b0);
    check("rst_data", i2c_data, 8'h00);
    check("rst_ready", in_ready, 1'b0);
    check("rst_init_done", init_done, 1'b0);
    check("rst_err", err, 1'b0);

    for (int n = 0; n < 4; n++) begin
      exp_q.push_back(pcf((n == 3) ? 4'h2 : 4'h3, 1'b1, 1'b1, 1'b0));
      exp_q.push_back(pcf((n == 3) ? 4'h2 : 4'h3, 1'b1, 1'b0, 1'b0));
    end

    // Character byte held valid through the whole init.
    rst = 1'b0;
    send_byte(8'h41, 1'b1, 1'b1, 46000, acc);
    check("ready_during_init", ready_init_bad, 0);
    check("init_done_after_100", done_cyc - fall_at(7), 101);
    check("accept_at_idle_entry", acc - done_cyc, 0);
    g = ena_at(2) - fall_at(1);
    check("init_gap_4100", (g >= 4101) && (g <= 4104), 1'b1);
    g = ena_at(6) - fall_at(5);
    check("init_gap_100", (g >= 101) && (g <= 104), 1'b1);
    prev_base = 8;
    prev_us   = 50;

    // Back-to-back random bytes; each acceptance lands right after the
    // previous settle delay (one edge to see the fall, then N cycles).
    for (int i = 0; i < 10; i++) begin
      d  = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      bl = 1'($urandom_range(0, 1));
      if (!rs && d <= 8'h03) d = d + 8'h10;
      busy_len = $urandom_range(1, 6);
      base = exp_q.size();
      send_byte(d, rs, bl, 3000, acc);
      check("post_dly", acc - fall_at(prev_base + 3), prev_us + 1);
      prev_base = base;
      prev_us   = post_us(d, rs);
    end

    // 0x04 is the first command past the clear/home range.
    busy_len = 5;
    base = exp_q.size();
    send_byte(8'h04, 1'b0, 1'b1, 3000, acc);
    check("post_dly_pre_cmd", acc - fall_at(prev_base + 3), prev_us + 1);
    prev_base = base;
    prev_us   = post_us(8'h04, 1'b0);

    clr_base = exp_q.size();
    send_byte(8'h01, 1'b0, 1'b0, 3000, acc);
    check("post_dly_cmd04", acc - fall_at(prev_base + 3), 51);

    base = exp_q.size();
    send_byte(8'h7A, 1'b1, 1'b1, 3000, acc);
    check("post_dly_clear", acc - fall_at(clr_base + 3), 2001);
    for (int k = 0; k < 200 && got_q.size() <= base; k++) @(negedge clk);
    check("clear_first_ena_gap", (ena_at(base) - fall_at(clr_base + 3)) >= 2000, 1'b1);
    wait_ready(200, rc);
    check("post_dly_last", rc - fall_at(base + 3), 51);

    // Writer busy for 200 cycles before the byte's first write.
    busy_hold = 1'b1;
    base = exp_q.size();
    send_byte(8'hC5, 1'b1, 1'b1, 10, acc);
    repeat (199) @(negedge clk);
    check("bp_no_write_while_busy", got_q.size(), base);
    busy_hold = 1'b0;
    g = cyc;
    wait_ready(200, rc);
    check("bp_ena_after_release", ena_at(base) > g, 1'b1);
    check("bp_one_ena_per_write", got_q.size(), base + 4);
    check("err_clear_before", err, 1'b0);

    // Error reported at the busy fall of the byte's second write.
    err_pick = w_issued + 2;
    base = exp_q.size();
    send_byte(8'h5E, 1'b1, 1'b1, 10, acc);
    wait_ready(200, rc);
    check("err_set", err, 1'b1);
    check("err_writes_continue", got_q.size(), base + 4);
    send_byte(8'h30, 1'b1, 1'b0, 10, acc);
    wait_ready(200, rc);
    check("err_sticky", err, 1'b1);

    // Reset during the third write's busy phase.
    busy_len = 6;
    base = exp_q.size();
    send_byte(8'hA7, 1'b1, 1'b1, 10, acc);
    void'(exp_q.pop_back());
    for (int k = 0; k < 200 && got_q.size() < base + 3; k++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("rst_in_busy", busy_w, 1'b1);
    chk_stable = 1'b0;
    backlight  = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ena", i2c_write_ena, 1'b0);
    check("midrst_init_done", init_done, 1'b0);
    check("midrst_ready", in_ready, 1'b0);
    check("midrst_err", err, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ena_next", i2c_write_ena, 1'b0);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h38);
    for (int k = 0; k < 41000 && got_q.size() < base + 5; k++) @(negedge clk);
    check("midrst_still_init", init_done, 1'b0);

    check("ena_protocol", ena_bad, 0);
    check("data_stable", stable_bad, 0);
    check("write_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("write%0d", i), (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
